// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher: one decryption round per clock.
// Round keys are read combinationally from an external pre-expanded key store via rk_idx.
module aes_inv_cipher (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic [3:0]   rk_idx,
   input  logic [127:0] rk_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

   fsm_t         fsm_reg, fsm_next;
   logic [127:0] state_reg, state_next;
   logic [3:0]   rnd_reg, rnd_next;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xt(aa);
      end
      return p;
   endfunction

   // Inverse affine map, then multiplicative inverse as x^254 (0 maps to 0).
   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] a, x2, x3, x6, x12, x15, x240, x252;
      a    = {b[1:0], b[7:2]} ^ {b[4:0], b[7:5]} ^ {b[6:0], b[7]} ^ 8'h05;
      x2   = gf_mul(a, a);
      x3   = gf_mul(x2, a);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x15  = gf_mul(x12, x3);
      x240 = gf_mul(x15, x15);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      x252 = gf_mul(x240, x12);
      return gf_mul(x252, x2);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
              gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
              gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
              gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
   endfunction

   logic [127:0] isr, isb, ark, imc;

   genvar gi;
   generate
      // Byte (r,c) takes byte (r,(c-r) mod 4): rows rotate right by r columns.
      for (gi = 0; gi < 16; gi++) begin : g_byte
         localparam int R   = gi % 4;
         localparam int C   = gi / 4;
         localparam int SRC = 4 * ((C - R + 4) % 4) + R;
         assign isr[127-8*gi -: 8] = state_reg[127-8*SRC -: 8];
         assign isb[127-8*gi -: 8] = inv_sbox(isr[127-8*gi -: 8]);
      end
      for (gi = 0; gi < 4; gi++) begin : g_col
         assign imc[127-32*gi -: 32] = inv_mix_col(ark[127-32*gi -: 32]);
      end
   endgenerate

   assign ark = isb ^ rk_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_reg   <= IDLE;
         state_reg <= '0;
         rnd_reg   <= '0;
      end else begin
         fsm_reg   <= fsm_next;
         state_reg <= state_next;
         rnd_reg   <= rnd_next;
      end
   end

   always_comb begin
      fsm_next   = fsm_reg;
      state_next = state_reg;
      rnd_next   = rnd_reg;
      case (fsm_reg)
         IDLE: begin
            if (in_valid) begin
               state_next = in_data ^ rk_data;
               rnd_next   = 4'd9;
               fsm_next   = ROUND;
            end
         end
         ROUND: begin
            if (rnd_reg != 4'd0) begin
               state_next = imc;
               rnd_next   = rnd_reg - 4'd1;
            end else begin
               state_next = ark;
               fsm_next   = DONE;
            end
         end
         DONE: begin
            if (out_ready) fsm_next = IDLE;
         end
         default: fsm_next = IDLE;
      endcase
   end

   // Handshake outputs decode the FSM register only.
   assign in_ready  = (fsm_reg == IDLE);
   assign out_valid = (fsm_reg == DONE);
   assign busy      = (fsm_reg != IDLE);
   assign rk_idx    = (fsm_reg == ROUND) ? rnd_reg : 4'd10;
   assign out_data  = state_reg;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed and randomized checks of aes_inv_cipher against a forward AES-128
// reference model and a key-store model built in this bench.
module tb_aes_inv_cipher;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;

   int errors = 0;
   int checks = 0;

   logic [7:0]   sbox [256];
   logic [127:0] ks [11];
   logic [3:0]   rk_log [11];

   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
   } vec_t;
   vec_t vecs [2];

   aes_inv_cipher dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .rk_idx    (rk_idx),
      .rk_data   (rk_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Key-store model: combinational lookup of the current rk_idx.
   always_comb begin
      rk_data = '0;
      if (rk_idx <= 4'd10) rk_data = ks[rk_idx];
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] q, input int n);
      return (q << n) | (q >> (8 - n));
   endfunction

   // Forward S-box from the generator-3 walk: p steps by *3, q by /3.
   task automatic build_sbox();
      logic [7:0] p, q;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         sbox[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
      end while (p != 8'h01);
      sbox[0] = 8'h63;
   endtask

   task automatic load_keys(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int j = 0; j < 11; j++) ks[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
   endtask

   function automatic logic [127:0] encrypt(input logic [127:0] pt);
      logic [127:0] s, t;
      logic [7:0]   a0, a1, a2, a3;
      s = pt ^ ks[0];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int k = 0; k < 16; k++) s[127-8*k -: 8] = sbox[s[127-8*k -: 8]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               t[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
         s = t;
         if (rnd != 10) begin
            for (int c = 0; c < 4; c++) begin
               {a0, a1, a2, a3} = s[127-32*c -: 32];
               s[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                    a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                    a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                    xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
            end
         end
         s = s ^ ks[rnd];
      end
      return s;
   endfunction

   // Waits (bounded) for in_ready, holds in_valid for one edge; returns at edge+1.
   task automatic accept(input logic [127:0] ct, input int stall);
      int w;
      w = 0;
      repeat (stall) begin @(posedge clk); #1; end
      while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
      check("in_ready_before_accept", 128'(in_ready), 128'd1);
      check("rk_idx_idle", 128'(rk_idx), 128'd10);
      in_valid = 1'b1;
      in_data  = ct;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Runs until the output handshake; reports latency from acceptance and the data seen.
   task automatic collect(input bit rand_ready, output logic [127:0] data, output int lat);
      int n;
      bit hs, done;
      n    = 0;
      lat  = -1;
      data = '0;
      done = 1'b0;
      rk_log[0] = rk_idx;
      while (!done && n < 200) begin
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
         hs = out_valid && out_ready;
         @(posedge clk); #1;
         n++;
         if (n <= 10) rk_log[n] = rk_idx;
         if (hs) done = 1'b1;
         else if (out_valid && lat < 0) begin
            lat  = n;
            data = out_data;
         end
      end
      check("handshake_done", 128'(done), 128'd1);
   endtask

   logic [127:0] got, key, pt, ct;
   int           lat, w;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      build_sbox();
      for (int j = 0; j < 11; j++) ks[j] = '0;

      vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                  ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  pt:  128'h00112233445566778899aabbccddeeff};
      vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  ct:  128'h3925841d02dc09fbdc118597196a0b32,
                  pt:  128'h3243f6a8885a308d313198a2e0370734};

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 128'(in_ready), 128'd1);
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_rk_idx", 128'(rk_idx), 128'd10);
      check("rst_out_data", out_data, 128'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors, out_ready held high.
      out_ready = 1'b1;
      for (int v = 0; v < 2; v++) begin
         load_keys(vecs[v].key);
         accept(vecs[v].ct, 0);
         check("busy_after_accept", 128'(busy), 128'd1);
         collect(1'b0, got, lat);
         check("vec_latency", 128'(lat), 128'd10);
         check("vec_plaintext", got, vecs[v].pt);
         for (int n = 0; n < 11; n++)
            check("rk_idx_seq", 128'(rk_log[n]), (n == 10) ? 128'd10 : 128'(9 - n));
         $display("vec %0d ct=%h pt=%h lat=%0d", v, vecs[v].ct, got, lat);
      end

      // Backpressure: hold out_ready low for 20 cycles with in_valid noise.
      load_keys(vecs[0].key);
      out_ready = 1'b0;
      accept(vecs[0].ct, 0);
      w = 0;
      while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
      check("bp_valid_rise", 128'(out_valid), 128'd1);
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'(i % 2);
         in_data  = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #1;
         check("bp_data_hold", out_data, vecs[0].pt);
         check("bp_valid_hold", 128'(out_valid), 128'd1);
         check("bp_in_ready_low", 128'(in_ready), 128'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", 128'(out_valid), 128'd0);
      check("bp_release_idle", 128'(busy), 128'd0);
      $display("backpressure pt=%h", out_data);

      // Back-to-back with in_valid held: acceptances must land 12 edges apart.
      load_keys(vecs[0].key);
      in_valid = 1'b1;
      in_data  = vecs[0].ct;
      @(posedge clk); #1;
      check("b2b_first_accept", 128'(busy), 128'd1);
      in_data = vecs[1].ct;
      repeat (10) @(posedge clk);
      #1;
      check("b2b_first_valid", 128'(out_valid), 128'd1);
      check("b2b_first_pt", out_data, vecs[0].pt);
      @(posedge clk); #1;
      check("b2b_idle_gap", 128'(in_ready), 128'd1);
      load_keys(vecs[1].key);
      @(posedge clk); #1;
      check("b2b_second_accept", 128'(busy), 128'd1);
      check("b2b_second_rk", 128'(rk_idx), 128'd9);
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("b2b_second_valid", 128'(out_valid), 128'd1);
      check("b2b_second_pt", out_data, vecs[1].pt);
      @(posedge clk); #1;
      check("b2b_done", 128'(out_valid), 128'd0);
      $display("back-to-back pt0=%h pt1=%h", vecs[0].pt, vecs[1].pt);

      // Asynchronous reset while rnd=5.
      load_keys(vecs[0].key);
      accept(vecs[0].ct, 0);
      w = 0;
      while (rk_idx != 4'd5 && w < 20) begin @(posedge clk); #1; w++; end
      check("mid_reach_rnd5", 128'(rk_idx), 128'd5);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 128'(out_valid), 128'd0);
      check("mid_rst_in_ready", 128'(in_ready), 128'd1);
      check("mid_rst_rk_idx", 128'(rk_idx), 128'd10);
      check("mid_rst_out_data", out_data, 128'd0);
      check("mid_rst_busy", 128'(busy), 128'd0);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      check("mid_post_idle", 128'(out_valid), 128'd0);
      accept(vecs[0].ct, 0);
      collect(1'b0, got, lat);
      check("mid_post_latency", 128'(lat), 128'd10);
      check("mid_post_pt", got, vecs[0].pt);
      $display("reset recovery pt=%h", got);

      // Random keys/plaintexts with random input and output stalls.
      for (int b = 0; b < 1000; b++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         load_keys(key);
         ct = encrypt(pt);
         out_ready = 1'($urandom_range(0, 1));
         accept(ct, $urandom_range(0, 3));
         collect(1'b1, got, lat);
         check("rand_latency", 128'(lat), 128'd10);
         check("rand_plaintext", got, pt);
         $display("rand %0d key=%h ct=%h pt=%h", b, key, ct, got);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
